unidade_controle_geogenius: RTL and testbench

//  Moore FSM that sequences fluxo_de_dados for one GeoGenius game.

---
 rtl/unidade_controle_geogenius.sv | 188 ++++++++++++++++++
 tb/tb_unidade_controle_geogenius.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_geogenius.sv
// GeoGenius game controller: a Moore FSM that sequences the datapath
// through one game. Each round shows the flag, waits for a button press
// or a timeout, scores the answer and shows the result. After the last
// round it holds the game frozen and exposes the total game time.
//
// state       | code | meaning
// ------------+------+-----------------------------------------------
// INICIAL     |  0   | idle after reset, waits for iniciar
// PREPARA     |  1   | clears every datapath counter/register
// NOVA_RODADA |  2   | clears round state, covers ROM read latency
// ESPERA      |  3   | flag on LEDs, round timer running, waits input
// REGISTRA    |  4   | latches the pressed button
// COMPARA     |  5   | compares latched button with the ROM flag
// ACERTO      |  6   | correct answer, one score increment
// ERRO        |  7   | wrong answer
// TIMEOUT     |  8   | no answer before the round timer expired
// RESULTADO   |  9   | result display timer running, flags held
// PROXIMA     | 10   | advances the round counter once
// FIM         | 11   | game over, shows total game time
module unidade_controle_geogenius #(
  parameter bit ERRO_ENCERRA = 1'b0,
  parameter int NUM_ESTADOS  = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fez_jogada,
  input  logic       jogada_igual_memoria,
  input  logic       ultima_jogada,
  input  logic       deu_timeout,
  input  logic       fim_timer_resultado,
  output logic       zera_contador_jogada,
  output logic       zera_contador_score,
  output logic       zera_timeout,
  output logic       zera_timer_resultado,
  output logic       zeraR,
  output logic       zera_tempo_de_jogo,
  output logic       conta_jogada,
  output logic       conta_score,
  output logic       conta_timeout,
  output logic       conta_timer_resultado,
  output logic       registraR,
  output logic       liga_led,
  output logic       mostra_tempo_de_jogo,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL     = 4'd0;
  localparam logic [3:0] PREPARA     = 4'd1;
  localparam logic [3:0] NOVA_RODADA = 4'd2;
  localparam logic [3:0] ESPERA      = 4'd3;
  localparam logic [3:0] REGISTRA    = 4'd4;
  localparam logic [3:0] COMPARA     = 4'd5;
  localparam logic [3:0] ACERTO      = 4'd6;
  localparam logic [3:0] ERRO        = 4'd7;
  localparam logic [3:0] TIMEOUT     = 4'd8;
  localparam logic [3:0] RESULTADO   = 4'd9;
  localparam logic [3:0] PROXIMA     = 4'd10;
  localparam logic [3:0] FIM         = 4'd11;

  // Highest legal code; anything above it is recovered to INICIAL.
  localparam logic [3:0] ULTIMO_ESTADO = 4'(NUM_ESTADOS - 1);

  logic [3:0] estado;
  logic [3:0] proximo_estado;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Next-state logic; fez_jogada wins over a coincident deu_timeout.
  always_comb begin
    proximo_estado = estado;
    if (estado > ULTIMO_ESTADO) begin
      proximo_estado = INICIAL;
    end else begin
      case (estado)
        INICIAL:     if (iniciar) proximo_estado = PREPARA;
        PREPARA:     proximo_estado = NOVA_RODADA;
        NOVA_RODADA: proximo_estado = ESPERA;
        ESPERA: begin
          if (fez_jogada) begin
            proximo_estado = REGISTRA;
          end else if (deu_timeout) begin
            proximo_estado = TIMEOUT;
          end
        end
        REGISTRA:    proximo_estado = COMPARA;
        COMPARA:     proximo_estado = jogada_igual_memoria ? ACERTO : ERRO;
        ACERTO:      proximo_estado = RESULTADO;
        ERRO:        proximo_estado = ERRO_ENCERRA ? FIM : RESULTADO;
        TIMEOUT:     proximo_estado = ERRO_ENCERRA ? FIM : RESULTADO;
        RESULTADO: begin
          if (fim_timer_resultado) begin
            proximo_estado = ultima_jogada ? FIM : PROXIMA;
          end
        end
        PROXIMA:     proximo_estado = NOVA_RODADA;
        FIM:         if (iniciar) proximo_estado = PREPARA;
        default:     proximo_estado = INICIAL;
      endcase
    end
  end

  // Result flags: cleared on entering a new round, set on entering the
  // outcome state and held through RESULTADO/FIM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acertou <= 1'b0;
      errou   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (proximo_estado)
        NOVA_RODADA: begin
          acertou <= 1'b0;
          errou   <= 1'b0;
          timeout <= 1'b0;
        end
        ACERTO:  acertou <= 1'b1;
        ERRO:    errou   <= 1'b1;
        TIMEOUT: timeout <= 1'b1;
        default: ;
      endcase
    end
  end

  // Control outputs decoded purely from the current state.
  always_comb begin
    zera_contador_jogada  = 1'b0;
    zera_contador_score   = 1'b0;
    zera_timeout          = 1'b0;
    zera_timer_resultado  = 1'b0;
    zeraR                 = 1'b0;
    zera_tempo_de_jogo    = 1'b0;
    conta_jogada          = 1'b0;
    conta_score           = 1'b0;
    conta_timeout         = 1'b0;
    conta_timer_resultado = 1'b0;
    registraR             = 1'b0;
    liga_led              = 1'b0;
    mostra_tempo_de_jogo  = 1'b0;
    pronto                = 1'b0;
    case (estado)
      PREPARA: begin
        zera_contador_jogada = 1'b1;
        zera_contador_score  = 1'b1;
        zera_timeout         = 1'b1;
        zera_timer_resultado = 1'b1;
        zeraR                = 1'b1;
        zera_tempo_de_jogo   = 1'b1;
      end
      NOVA_RODADA: begin
        zera_timeout         = 1'b1;
        zeraR                = 1'b1;
        zera_timer_resultado = 1'b1;
      end
      ESPERA: begin
        liga_led      = 1'b1;
        conta_timeout = 1'b1;
      end
      REGISTRA: begin
        registraR = 1'b1;
        liga_led  = 1'b1;
      end
      COMPARA:   liga_led              = 1'b1;
      ACERTO:    conta_score           = 1'b1;
      RESULTADO: conta_timer_resultado = 1'b1;
      PROXIMA:   conta_jogada          = 1'b1;
      FIM: begin
        pronto               = 1'b1;
        mostra_tempo_de_jogo = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_geogenius.sv
// Bench for the GeoGenius controller: a directed walk through the state
// table plus randomized games checked against a round-outcome model, on
// one instance that keeps playing after errors and one that stops.
module tb_unidade_controle_geogenius;

  localparam logic [3:0] S_INICIAL   = 4'd0;
  localparam logic [3:0] S_ESPERA    = 4'd3;
  localparam logic [3:0] S_REGISTRA  = 4'd4;
  localparam logic [3:0] S_TIMEOUT   = 4'd8;
  localparam logic [3:0] S_RESULTADO = 4'd9;
  localparam logic [3:0] S_PROXIMA   = 4'd10;
  localparam logic [3:0] S_FIM       = 4'd11;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0;
  logic fez_jogada = 1'b0;
  logic jogada_igual_memoria = 1'b0;
  logic ultima_jogada = 1'b0;
  logic deu_timeout = 1'b0;
  logic fim_timer_resultado = 1'b0;

  // ctrl bits: 13 zcj,12 zcs,11 zt,10 ztr,9 zR,8 ztj,7 cj,6 cs,5 ct,4 ctr,3 reg,2 led,1 mtj,0 pronto
  logic [13:0] ctrl, ctrl_e;
  logic [2:0]  fl, fl_e;       // {acertou, errou, timeout}
  logic [3:0]  st, st_e;

  int checks = 0;
  int passes = 0;

  bit mon_en = 1'b0;
  bit mon_enc = 1'b0;
  int n_score = 0;
  int n_jog = 0;

  always #5 clock = ~clock;

  unidade_controle_geogenius #(.ERRO_ENCERRA(1'b0), .NUM_ESTADOS(12)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fez_jogada(fez_jogada),
    .jogada_igual_memoria(jogada_igual_memoria), .ultima_jogada(ultima_jogada),
    .deu_timeout(deu_timeout), .fim_timer_resultado(fim_timer_resultado),
    .zera_contador_jogada(ctrl[13]), .zera_contador_score(ctrl[12]),
    .zera_timeout(ctrl[11]), .zera_timer_resultado(ctrl[10]), .zeraR(ctrl[9]),
    .zera_tempo_de_jogo(ctrl[8]), .conta_jogada(ctrl[7]), .conta_score(ctrl[6]),
    .conta_timeout(ctrl[5]), .conta_timer_resultado(ctrl[4]), .registraR(ctrl[3]),
    .liga_led(ctrl[2]), .mostra_tempo_de_jogo(ctrl[1]), .pronto(ctrl[0]),
    .acertou(fl[2]), .errou(fl[1]), .timeout(fl[0]), .db_estado(st)
  );

  unidade_controle_geogenius #(.ERRO_ENCERRA(1'b1), .NUM_ESTADOS(12)) dut_enc (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fez_jogada(fez_jogada),
    .jogada_igual_memoria(jogada_igual_memoria), .ultima_jogada(ultima_jogada),
    .deu_timeout(deu_timeout), .fim_timer_resultado(fim_timer_resultado),
    .zera_contador_jogada(ctrl_e[13]), .zera_contador_score(ctrl_e[12]),
    .zera_timeout(ctrl_e[11]), .zera_timer_resultado(ctrl_e[10]), .zeraR(ctrl_e[9]),
    .zera_tempo_de_jogo(ctrl_e[8]), .conta_jogada(ctrl_e[7]), .conta_score(ctrl_e[6]),
    .conta_timeout(ctrl_e[5]), .conta_timer_resultado(ctrl_e[4]), .registraR(ctrl_e[3]),
    .liga_led(ctrl_e[2]), .mostra_tempo_de_jogo(ctrl_e[1]), .pronto(ctrl_e[0]),
    .acertou(fl_e[2]), .errou(fl_e[1]), .timeout(fl_e[0]), .db_estado(st_e)
  );

  // Pulse counters for the instance currently under test.
  always @(negedge clock) begin
    if (mon_en) begin
      if (mon_enc ? ctrl_e[6] : ctrl[6]) n_score++;
      if (mon_enc ? ctrl_e[7] : ctrl[7]) n_jog++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Control outputs expected in each state, straight from the state table.
  function automatic logic [13:0] exp_ctrl(input logic [3:0] code);
    case (code)
      4'd1:    return 14'b11111100000000;
      4'd2:    return 14'b00111000000000;
      4'd3:    return 14'b00000000100100;
      4'd4:    return 14'b00000000001100;
      4'd5:    return 14'b00000000000100;
      4'd6:    return 14'b00000001000000;
      4'd9:    return 14'b00000000010000;
      4'd10:   return 14'b00000010000000;
      4'd11:   return 14'b00000000000011;
      default: return 14'b0;
    endcase
  endfunction

  function automatic logic [3:0] cur_st(input bit enc);
    return enc ? st_e : st;
  endfunction

  function automatic logic [2:0] cur_fl(input bit enc);
    return enc ? fl_e : fl;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    iniciar = 1'b0;
    fez_jogada = 1'b0;
    deu_timeout = 1'b0;
    jogada_igual_memoria = 1'b0;
    ultima_jogada = 1'b0;
    fim_timer_resultado = 1'b0;
  endtask

  task automatic test_reset(input string where);
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (st !== S_INICIAL || st_e !== S_INICIAL) $display("FAIL reset_state(%s): got %0d/%0d want 0", where, st, st_e);
    else passes++;
    checks++;
    if (ctrl !== 14'b0 || ctrl_e !== 14'b0) $display("FAIL reset_ctrl(%s): got %b/%b want 0", where, ctrl, ctrl_e);
    else passes++;
    checks++;
    if (fl !== 3'b0 || fl_e !== 3'b0) $display("FAIL reset_flags(%s): got %b/%b want 000", where, fl, fl_e);
    else passes++;
    reset = 1'b1;
  endtask

  // Directed walk: {iniciar,fez,deu,igual,ultima,fim} applied, then state,
  // flags and flag-check enable expected after the next edge.
  task automatic test_sequence();
    logic [13:0] seq [30];
    logic [3:0] es;
    seq = '{
      {6'b100000, 4'd1,  3'b000, 1'b1},
      {6'b000000, 4'd2,  3'b000, 1'b1},
      {6'b000000, 4'd3,  3'b000, 1'b1},
      {6'b010100, 4'd4,  3'b000, 1'b1},
      {6'b000100, 4'd5,  3'b000, 1'b1},
      {6'b000100, 4'd6,  3'b100, 1'b0},
      {6'b000000, 4'd9,  3'b100, 1'b1},
      {6'b000001, 4'd10, 3'b100, 1'b1},
      {6'b000000, 4'd2,  3'b000, 1'b1},
      {6'b000000, 4'd3,  3'b000, 1'b1},
      {6'b000000, 4'd3,  3'b000, 1'b1},
      {6'b001000, 4'd8,  3'b001, 1'b0},
      {6'b000000, 4'd9,  3'b001, 1'b1},
      {6'b000000, 4'd9,  3'b001, 1'b1},
      {6'b010000, 4'd9,  3'b001, 1'b1},
      {6'b000011, 4'd11, 3'b001, 1'b1},
      {6'b000000, 4'd11, 3'b001, 1'b1},
      {6'b100000, 4'd1,  3'b001, 1'b0},
      {6'b000000, 4'd2,  3'b000, 1'b1},
      {6'b000000, 4'd3,  3'b000, 1'b1},
      {6'b010000, 4'd4,  3'b000, 1'b1},
      {6'b000000, 4'd5,  3'b000, 1'b1},
      {6'b000000, 4'd7,  3'b010, 1'b0},
      {6'b000000, 4'd9,  3'b010, 1'b1},
      {6'b000001, 4'd10, 3'b010, 1'b1},
      {6'b000000, 4'd2,  3'b000, 1'b1},
      {6'b000000, 4'd3,  3'b000, 1'b1},
      {6'b011100, 4'd4,  3'b000, 1'b1},
      {6'b000100, 4'd5,  3'b000, 1'b1},
      {6'b000100, 4'd6,  3'b100, 1'b0}
    };
    for (int i = 0; i < 30; i++) begin
      {iniciar, fez_jogada, deu_timeout, jogada_igual_memoria, ultima_jogada, fim_timer_resultado} = seq[i][13:8];
      step();
      es = seq[i][7:4];
      checks++;
      if (st !== es) $display("FAIL seq_state step %0d: got %0d want %0d", i, st, es);
      else passes++;
      checks++;
      if (ctrl !== exp_ctrl(es)) $display("FAIL seq_ctrl step %0d: got %b want %b", i, ctrl, exp_ctrl(es));
      else passes++;
      if (seq[i][0]) begin
        checks++;
        if (fl !== seq[i][3:1]) $display("FAIL seq_flags step %0d: got %b want %b", i, fl, seq[i][3:1]);
        else passes++;
      end
    end
    clear_inputs();
  endtask

  // Random game; kind 0 = press, 1 = timeout, 2 = press and timeout together.
  task automatic test_game(input bit enc);
    int n, guard, exp_score, exp_jog;
    int kind [8];
    bit igual [8];
    bit ended, correct, abort;
    logic [2:0] exp_fl, rnd_fl;
    n = $urandom_range(2, 6);
    for (int r = 0; r < n; r++) begin
      kind[r] = $urandom_range(0, 2);
      igual[r] = ($urandom_range(0, 3) != 0);
    end
    exp_score = 0; exp_jog = 0; ended = 1'b0; exp_fl = 3'b000;
    for (int r = 0; r < n; r++) begin
      if (!ended) begin
        correct = (kind[r] != 1) && igual[r];
        if (correct) exp_score++;
        exp_fl = correct ? 3'b100 : ((kind[r] == 1) ? 3'b001 : 3'b010);
        if (enc && !correct) ended = 1'b1;
        else if (r < n - 1) exp_jog++;
      end
    end

    test_reset(enc ? "game_enc" : "game");
    mon_enc = enc; n_score = 0; n_jog = 0; mon_en = 1'b1; abort = 1'b0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int r = 0; r < n && !abort; r++) begin
      correct = (kind[r] != 1) && igual[r];
      rnd_fl = correct ? 3'b100 : ((kind[r] == 1) ? 3'b001 : 3'b010);
      guard = 0;
      while (cur_st(enc) !== S_ESPERA && guard < 10) begin step(); guard++; end
      checks++;
      if (cur_st(enc) !== S_ESPERA) begin
        $display("FAIL game_wait_espera round %0d: got %0d want 3", r, cur_st(enc));
        abort = 1'b1;
      end else passes++;
      if (!abort) begin
        jogada_igual_memoria = igual[r];
        ultima_jogada = (r == n - 1);
        repeat ($urandom_range(0, 4)) step();
        fez_jogada = (kind[r] != 1);
        deu_timeout = (kind[r] != 0);
        step();
        fez_jogada = 1'b0;
        deu_timeout = 1'b0;
        checks++;
        if (cur_st(enc) !== ((kind[r] == 1) ? S_TIMEOUT : S_REGISTRA))
          $display("FAIL game_after_input round %0d kind %0d: got %0d", r, kind[r], cur_st(enc));
        else passes++;
        guard = 0;
        while (cur_st(enc) !== S_RESULTADO && cur_st(enc) !== S_FIM && guard < 10) begin step(); guard++; end
        if (enc && !correct) begin
          checks++;
          if (cur_st(enc) !== S_FIM) $display("FAIL game_enc_stop round %0d: got %0d want 11", r, cur_st(enc));
          else passes++;
          break;
        end
        checks++;
        if (cur_st(enc) !== S_RESULTADO) begin
          $display("FAIL game_resultado round %0d: got %0d want 9", r, cur_st(enc));
          abort = 1'b1;
        end else passes++;
        checks++;
        if (cur_fl(enc) !== rnd_fl) $display("FAIL game_round_flags round %0d: got %b want %b", r, cur_fl(enc), rnd_fl);
        else passes++;
        if (!abort) begin
          repeat ($urandom_range(0, 3)) step();
          fim_timer_resultado = 1'b1;
          step();
          fim_timer_resultado = 1'b0;
          checks++;
          if (cur_st(enc) !== ((r == n - 1) ? S_FIM : S_PROXIMA))
            $display("FAIL game_after_result round %0d: got %0d", r, cur_st(enc));
          else passes++;
        end
      end
    end
    step();
    step();
    mon_en = 1'b0;
    checks++;
    if (cur_st(enc) !== S_FIM || (enc ? ctrl_e[0] : ctrl[0]) !== 1'b1)
      $display("FAIL game_end: state %0d pronto %b want 11/1", cur_st(enc), enc ? ctrl_e[0] : ctrl[0]);
    else passes++;
    checks++;
    if (cur_fl(enc) !== exp_fl) $display("FAIL game_final_flags: got %b want %b", cur_fl(enc), exp_fl);
    else passes++;
    checks++;
    if (n_score !== exp_score) $display("FAIL game_score_pulses: got %0d want %0d", n_score, exp_score);
    else passes++;
    checks++;
    if (n_jog !== exp_jog) $display("FAIL game_jogada_pulses: got %0d want %0d", n_jog, exp_jog);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_reset_in_resultado();
    int guard;
    test_reset("pre_resultado");
    mon_enc = 1'b0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    guard = 0;
    while (st !== S_ESPERA && guard < 10) begin step(); guard++; end
    jogada_igual_memoria = 1'b1;
    fez_jogada = 1'b1;
    step();
    fez_jogada = 1'b0;
    guard = 0;
    while (st !== S_RESULTADO && guard < 10) begin step(); guard++; end
    checks++;
    if (st !== S_RESULTADO) $display("FAIL rst_res_reach: got %0d want 9", st);
    else passes++;
    n_jog = 0;
    mon_en = 1'b1;
    fim_timer_resultado = 1'b1;
    ultima_jogada = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (st !== S_INICIAL || ctrl !== 14'b0 || fl !== 3'b0)
      $display("FAIL rst_res_state: got state %0d ctrl %b flags %b want 0", st, ctrl, fl);
    else passes++;
    reset = 1'b1;
    fim_timer_resultado = 1'b0;
    step();
    step();
    mon_en = 1'b0;
    checks++;
    if (n_jog !== 0) $display("FAIL rst_res_no_jogada: got %0d pulses want 0", n_jog);
    else passes++;
    clear_inputs();
  endtask

  initial begin
    test_reset("power_on");
    test_sequence();
    test_reset("mid_game");
    repeat (6) test_game(1'b0);
    test_reset("from_fim");
    repeat (6) test_game(1'b1);
    test_reset_in_resultado();
    test_reset("final");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
